// File: rtl/cell_painter.sv
// Board cell rasteriser: expands a cell plot request into CELL x CELL
// pixel writes, drawing a corner-clipped disk or plain background.
module cell_painter #(
    parameter int          CELL         = 12,
    parameter int          CORNER       = 3,
    parameter logic [2:0]  BG_COLOUR    = 3'b010,
    parameter logic [2:0]  SIDE0_COLOUR = 3'b000,
    parameter logic [2:0]  SIDE1_COLOUR = 3'b111
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] x_plot,
    input  logic [6:0] y_plot,
    input  logic [1:0] select,
    input  logic       enable,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       overflow
);

    localparam int DW = 5;
    localparam logic [DW-1:0] LIM = DW'(CELL - 1);

    typedef enum logic {IDLE, DRAW} state_t;

    state_t        state;
    logic [7:0]    xb, hx;
    logic [6:0]    yb, hy;
    logic [1:0]    sel, hsel;
    logic          h_valid;
    logic [DW-1:0] dx, dy;

    logic [DW-1:0] rx, ry, ex, ey;
    logic [DW:0]   esum;
    logic          corner, row_end, cell_end;
    logic [2:0]    pix_colour;

    always_comb begin
        rx       = LIM - dx;
        ry       = LIM - dy;
        ex       = (dx < rx) ? dx : rx;
        ey       = (dy < ry) ? dy : ry;
        esum     = {1'b0, ex} + {1'b0, ey};
        corner   = esum < (DW+1)'(CORNER);
        row_end  = dx == LIM;
        cell_end = row_end && (dy == LIM);
        pix_colour = BG_COLOUR;
        if (sel[1] && !corner)
            pix_colour = sel[0] ? SIDE1_COLOUR : SIDE0_COLOUR;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            xb       <= '0;
            yb       <= '0;
            sel      <= '0;
            hx       <= '0;
            hy       <= '0;
            hsel     <= '0;
            h_valid  <= 1'b0;
            dx       <= '0;
            dy       <= '0;
            vga_x    <= '0;
            vga_y    <= '0;
            colour   <= '0;
            plot     <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    plot <= 1'b0;
                    dx   <= '0;
                    dy   <= '0;
                    busy <= enable | h_valid;
                    if (enable) begin
                        // Fresh request jumps ahead; any held one is served next
                        xb    <= x_plot;
                        yb    <= y_plot;
                        sel   <= select;
                        state <= DRAW;
                    end else if (h_valid) begin
                        xb      <= hx;
                        yb      <= hy;
                        sel     <= hsel;
                        h_valid <= 1'b0;
                        state   <= DRAW;
                    end
                end
                DRAW: begin
                    vga_x  <= xb + 8'(dx);
                    vga_y  <= yb + 7'(dy);
                    colour <= pix_colour;
                    plot   <= 1'b1;
                    if (enable) begin
                        if (!h_valid) begin
                            hx      <= x_plot;
                            hy      <= y_plot;
                            hsel    <= select;
                            h_valid <= 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    if (row_end) begin
                        dx <= '0;
                        dy <= dy + 1'b1;
                    end else begin
                        dx <= dx + 1'b1;
                    end
                    if (cell_end) begin
                        state <= IDLE;
                        dy    <= '0;
                        busy  <= h_valid | enable;
                    end else begin
                        busy <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_painter.sv
// Directed bench for cell_painter: table of single-cell requests plus
// hand sequences for hold buffer, overflow, wrap and mid-draw reset.
module tb_cell_painter;

    localparam int CELL = 12;
    localparam int NPIX = CELL * CELL;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] x_plot = '0;
    logic [6:0] y_plot = '0;
    logic [1:0] select = '0;
    logic       enable = 1'b0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot, busy, overflow;

    cell_painter dut (
        .clock(clock), .resetn(resetn),
        .x_plot(x_plot), .y_plot(y_plot),
        .select(select), .enable(enable),
        .vga_x(vga_x), .vga_y(vga_y),
        .colour(colour), .plot(plot),
        .busy(busy), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x; int y; int c; int cyc;
    } pix_t;

    typedef struct {
        int x; int y; int sel;
        int c00; int c30; int cmid;
        int last_x; int last_y;
    } vec_t;

    pix_t q[$];
    int   cyc = 0;
    int   ncmp = 0;
    int   nfail = 0;
    int   req_cyc;

    always @(posedge clock) cyc++;

    always @(negedge clock)
        if (plot) q.push_back('{int'(vga_x), int'(vga_y), int'(colour), cyc});

    task automatic check(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected colour: distance from nearest x edge plus nearest y edge
    function automatic int ref_colour(input int dx, input int dy, input int s);
        int ex, ey;
        ex = (dx <= CELL - 1 - dx) ? dx : CELL - 1 - dx;
        ey = (dy <= CELL - 1 - dy) ? dy : CELL - 1 - dy;
        if (s < 2) return 2;
        if (ex + ey < 3) return 2;
        return (s == 3) ? 7 : 0;
    endfunction

    task automatic req(input int x, input int y, input int s);
        @(negedge clock);
        x_plot  = 8'(x);
        y_plot  = 7'(y);
        select  = 2'(s);
        enable  = 1'b1;
        req_cyc = cyc + 1;
        @(negedge clock);
        enable  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clock);
        while ((busy || plot) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 1000) check({name, " idle timeout"}, 1, 0);
    endtask

    task automatic wait_pixels(input string name, input int cnt);
        int n;
        n = 0;
        while (q.size() < cnt && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 1000) check({name, " pixel timeout"}, q.size(), cnt);
    endtask

    task automatic check_cell(input string name, input int base,
                              input int x, input int y, input int s);
        int errs;
        errs = 0;
        if (q.size() < base + NPIX) begin
            check({name, " short"}, q.size(), base + NPIX);
            return;
        end
        for (int i = 0; i < NPIX; i++) begin
            int dx, dy;
            dx = i % CELL;
            dy = i / CELL;
            if (q[base+i].x != (x + dx) % 256) errs++;
            if (q[base+i].y != (y + dy) % 128) errs++;
            if (q[base+i].c != ref_colour(dx, dy, s)) errs++;
            if (q[base+i].cyc != q[base].cyc + i) errs++;
        end
        check({name, " pixel errors"}, errs, 0);
    endtask

    vec_t vt[5];

    initial begin
        vt[0] = '{9, 9, 3, 2, 7, 7, 20, 20};
        vt[1] = '{22, 35, 1, 2, 2, 2, 33, 46};
        vt[2] = '{250, 120, 2, 2, 0, 0, 5, 3};
        vt[3] = '{0, 0, 0, 2, 2, 2, 11, 11};
        vt[4] = '{100, 50, 2, 2, 0, 0, 111, 61};

        #1;
        check("rst plot", int'(plot), 0);
        check("rst busy", int'(busy), 0);
        check("rst overflow", int'(overflow), 0);
        check("rst vga_x", int'(vga_x), 0);
        check("rst vga_y", int'(vga_y), 0);
        check("rst colour", int'(colour), 0);
        #22;
        resetn = 1'b1;

        foreach (vt[k]) begin
            q.delete();
            req(vt[k].x, vt[k].y, vt[k].sel);
            wait_idle("vec");
            check("vec count", q.size(), NPIX);
            if (q.size() == NPIX) begin
                check("vec latency", q[0].cyc, req_cyc + 1);
                check("vec c00", q[0].c, vt[k].c00);
                check("vec c30", q[3].c, vt[k].c30);
                check("vec c03", q[3*CELL].c, vt[k].c30);
                check("vec c11", q[CELL+1].c, 2);
                check("vec cmid", q[6*CELL+6].c, vt[k].cmid);
                check("vec last x", q[NPIX-1].x, vt[k].last_x);
                check("vec last y", q[NPIX-1].y, vt[k].last_y);
                check("vec last c", q[NPIX-1].c, 2);
            end
            check_cell("vec", 0, vt[k].x, vt[k].y, vt[k].sel);
            check("vec busy", int'(busy), 0);
            check("vec overflow", int'(overflow), 0);
        end

        // Second request mid-draw is held and served after one bubble
        q.delete();
        req(30, 30, 2);
        wait_pixels("hold", 50);
        req(60, 60, 3);
        check("hold busy", int'(busy), 1);
        wait_idle("hold");
        check("hold count", q.size(), 2 * NPIX);
        check_cell("hold A", 0, 30, 30, 2);
        check_cell("hold B", NPIX, 60, 60, 3);
        if (q.size() == 2 * NPIX)
            check("hold bubble", q[NPIX].cyc - q[NPIX-1].cyc, 2);
        check("hold overflow", int'(overflow), 0);

        // Third request while hold is full is dropped
        q.delete();
        req(40, 10, 3);
        wait_pixels("ovf", 5);
        req(70, 20, 2);
        req(90, 30, 1);
        check("ovf flag", int'(overflow), 1);
        wait_idle("ovf");
        check("ovf count", q.size(), 2 * NPIX);
        check_cell("ovf A", 0, 40, 10, 3);
        check_cell("ovf B", NPIX, 70, 20, 2);
        check("ovf sticky", int'(overflow), 1);

        // Reset mid-draw aborts at once and clears overflow
        q.delete();
        req(5, 5, 3);
        wait_pixels("rst", 70);
        #2;
        resetn = 1'b0;
        #1;
        check("mid rst plot", int'(plot), 0);
        check("mid rst busy", int'(busy), 0);
        check("mid rst overflow", int'(overflow), 0);
        @(negedge clock);
        resetn = 1'b1;
        q.delete();
        req(16, 40, 3);
        wait_idle("post rst");
        check("post rst count", q.size(), NPIX);
        check_cell("post rst", 0, 16, 40, 3);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
        $finish;
    end

endmodule
